// File: rtl/soc_reset_sequencer.sv
// Board-level power-up/reset sequencer: waits for PLL lock, settles, enables the
// SoC clock, then releases SoC reset. Define WATCHDOG_EN to add the watchdog.
module soc_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int CLKEN_LEAD      = 16,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       reset_button_n,
  input  logic       wdt_kick,
  output logic       soc_clk_en,
  output logic       soc_rst,
  output logic [2:0] state,
  output logic [1:0] reset_cause
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_CLK_ON    = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  localparam logic [1:0] CAUSE_POR    = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_LOCK   = 2'd2;
  localparam logic [1:0] CAUSE_WDT    = 2'd3;

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int LEAD_W = (CLKEN_LEAD > 1) ? $clog2(CLKEN_LEAD) : 1;

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CYCLES);
  localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(CLKEN_LEAD - 1);

  // Input synchronizers; intentionally not reset so they keep tracking during rst.
  logic [SYNC_STAGES-1:0] lock_sync_reg;
  logic [SYNC_STAGES-1:0] btn_sync_reg;
  logic                   lock_s;
  logic                   btn_s;

  always_ff @(posedge clk) begin
    lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], pll_locked};
    btn_sync_reg  <= {btn_sync_reg[SYNC_STAGES-2:0], reset_button_n};
  end

  assign lock_s = lock_sync_reg[SYNC_STAGES-1];
  assign btn_s  = btn_sync_reg[SYNC_STAGES-1];

  // Debounce: a press is accepted on the DEBOUNCE_CYCLES-th consecutive low sample.
  logic [DEB_W-1:0] deb_cnt_reg;
  logic [DEB_W-1:0] deb_cnt_next;
  logic             btn_press;

  always_comb begin
    deb_cnt_next = deb_cnt_reg;
    if (btn_s) begin
      deb_cnt_next = '0;
    end else if (deb_cnt_reg != DEB_MAX) begin
      deb_cnt_next = deb_cnt_reg + 1'b1;
    end
  end

  assign btn_press = !btn_s && (deb_cnt_reg == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_reg <= '0;
    end else begin
      deb_cnt_reg <= deb_cnt_next;
    end
  end

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic [1:0]        cause_reg;
  logic [1:0]        cause_next;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic [STAB_W-1:0] stab_cnt_next;
  logic [LEAD_W-1:0] lead_cnt_reg;
  logic [LEAD_W-1:0] lead_cnt_next;
  logic              soc_rst_reg;
  logic              soc_clk_en_reg;
  logic              wdt_timeout;

`ifdef WATCHDOG_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_reg;
  logic [WDT_W-1:0] wdt_cnt_next;

  assign wdt_timeout = (state_reg == S_RUN) && !wdt_kick && (wdt_cnt_reg == WDT_LAST);

  // Only counts across consecutive RUN cycles; any exit from RUN clears it.
  always_comb begin
    wdt_cnt_next = '0;
    if ((state_reg == S_RUN) && (state_next == S_RUN) && !wdt_kick) begin
      wdt_cnt_next = wdt_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_reg <= '0;
    end else begin
      wdt_cnt_reg <= wdt_cnt_next;
    end
  end
`else
  logic unused_wdt_kick;

  assign unused_wdt_kick = wdt_kick;
  assign wdt_timeout     = 1'b0;
`endif

  // Fault priority inside each state: lock loss, then button, then watchdog.
  always_comb begin
    state_next    = state_reg;
    cause_next    = cause_reg;
    stab_cnt_next = stab_cnt_reg;
    lead_cnt_next = lead_cnt_reg;

    case (state_reg)
      S_RESET: begin
        state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s && btn_s) begin
          state_next = S_STABILIZE;
        end
      end
      S_STABILIZE: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
        end else if (btn_press) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_BUTTON;
        end else if (stab_cnt_reg == STAB_DONE) begin
          state_next = S_CLK_ON;
        end else begin
          stab_cnt_next = stab_cnt_reg + 1'b1;
        end
      end
      S_CLK_ON: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_LOCK;
        end else if (btn_press) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_BUTTON;
        end else if (lead_cnt_reg == LEAD_LAST) begin
          state_next = S_RUN;
        end else begin
          lead_cnt_next = lead_cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_LOCK;
        end else if (btn_press) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_BUTTON;
        end else if (wdt_timeout) begin
          state_next = S_WAIT_LOCK;
          cause_next = CAUSE_WDT;
        end
      end
      default: begin
        state_next = S_RESET;
      end
    endcase

    if (state_next != S_STABILIZE) begin
      stab_cnt_next = '0;
    end
    if (state_next != S_CLK_ON) begin
      lead_cnt_next = '0;
    end
  end

  // Outputs are decoded from the next state so they change together with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_RESET;
      cause_reg      <= CAUSE_POR;
      stab_cnt_reg   <= '0;
      lead_cnt_reg   <= '0;
      soc_rst_reg    <= 1'b1;
      soc_clk_en_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cause_reg      <= cause_next;
      stab_cnt_reg   <= stab_cnt_next;
      lead_cnt_reg   <= lead_cnt_next;
      soc_rst_reg    <= (state_next != S_RUN);
      soc_clk_en_reg <= (state_next == S_CLK_ON) || (state_next == S_RUN);
    end
  end

  assign state       = state_reg;
  assign reset_cause = cause_reg;
  assign soc_rst     = soc_rst_reg;
  assign soc_clk_en  = soc_clk_en_reg;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer with small timing parameters.
// Expected cycle counts are hand-derived from the sequencing rules.
module tb_soc_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       reset_button_n;
  logic       wdt_kick;
  logic       soc_clk_en;
  logic       soc_rst;
  logic [2:0] state;
  logic [1:0] reset_cause;

  int checks = 0;
  int errors = 0;

  soc_reset_sequencer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .STABLE_CYCLES  (8),
    .CLKEN_LEAD     (3),
    .WDT_CYCLES     (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .reset_button_n(reset_button_n),
    .wdt_kick      (wdt_kick),
    .soc_clk_en    (soc_clk_en),
    .soc_rst       (soc_rst),
    .state         (state),
    .reset_cause   (reset_cause)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] st, input logic rs,
                           input logic ce, input logic [1:0] cause);
    check({tag, "_state"}, {5'd0, state}, {5'd0, st});
    check({tag, "_soc_rst"}, {7'd0, soc_rst}, {7'd0, rs});
    check({tag, "_clk_en"}, {7'd0, soc_clk_en}, {7'd0, ce});
    check({tag, "_cause"}, {6'd0, reset_cause}, {6'd0, cause});
  endtask

  initial begin
    rst            = 1'b1;
    pll_locked     = 1'b1;
    reset_button_n = 1'b1;
    wdt_kick       = 1'b0;

    // Power-up: reset held, then a clean sequence to RUN.
    tick(5);
    check_out("por", 3'd0, 1'b1, 1'b0, 2'd0);
    rst = 1'b0;
    tick(1);
    check_out("e0", 3'd1, 1'b1, 1'b0, 2'd0);
    tick(9);
    check_out("e9", 3'd2, 1'b1, 1'b0, 2'd0);
    tick(1);
    check_out("e10_clk_on", 3'd3, 1'b1, 1'b1, 2'd0);
    tick(2);
    check_out("e12_lead", 3'd3, 1'b1, 1'b1, 2'd0);
    tick(1);
    check_out("e13_run", 3'd4, 1'b0, 1'b1, 2'd0);
    $display("txn power_up: state=%0d soc_rst=%0b clk_en=%0b cause=%0d", state, soc_rst, soc_clk_en, reset_cause);

    // rst during RUN forces S_RESET on the next cycle.
    rst = 1'b1;
    tick(1);
    check_out("rst_in_run", 3'd0, 1'b1, 1'b0, 2'd0);
    rst = 1'b0;

    // Lock glitch during STABILIZE restarts the stabilize count.
    tick(6);
    check_out("stab_before_glitch", 3'd2, 1'b1, 1'b0, 2'd0);
    pll_locked = 1'b0;
    tick(2);
    check_out("glitch_not_yet_seen", 3'd2, 1'b1, 1'b0, 2'd0);
    pll_locked = 1'b1;
    tick(1);
    check_out("glitch_wait_lock", 3'd1, 1'b1, 1'b0, 2'd0);
    tick(10);
    check_out("relock_e18", 3'd2, 1'b1, 1'b0, 2'd0);
    tick(1);
    check_out("relock_clk_on", 3'd3, 1'b1, 1'b1, 2'd0);
    tick(3);
    check_out("relock_run", 3'd4, 1'b0, 1'b1, 2'd0);
    $display("txn stab_glitch: state=%0d cause=%0d", state, reset_cause);

    // Lock loss in RUN: seen after SYNC_STAGES+1 edges, cause=2.
    pll_locked = 1'b0;
    tick(2);
    check_out("lockloss_pending", 3'd4, 1'b0, 1'b1, 2'd0);
    tick(1);
    check_out("lockloss", 3'd1, 1'b1, 1'b0, 2'd2);
    pll_locked = 1'b1;
    tick(14);
    check_out("lockloss_clk_on", 3'd3, 1'b1, 1'b1, 2'd2);
    tick(1);
    check_out("lockloss_run", 3'd4, 1'b0, 1'b1, 2'd2);
    $display("txn lock_loss: state=%0d cause=%0d", state, reset_cause);

    // Button low 3 cycles: below the debounce threshold.
    reset_button_n = 1'b0;
    tick(3);
    reset_button_n = 1'b1;
    tick(5);
    check_out("btn3_ignored", 3'd4, 1'b0, 1'b1, 2'd2);
    $display("txn btn_short: state=%0d cause=%0d", state, reset_cause);

    // Button held: press accepted on the 4th low sample, stays in WAIT_LOCK while held.
    reset_button_n = 1'b0;
    tick(5);
    check_out("btn_pending", 3'd4, 1'b0, 1'b1, 2'd2);
    tick(1);
    check_out("btn_press", 3'd1, 1'b1, 1'b0, 2'd1);
    tick(10);
    check_out("btn_held", 3'd1, 1'b1, 1'b0, 2'd1);
    reset_button_n = 1'b1;
    tick(2);
    check_out("btn_release_sync", 3'd1, 1'b1, 1'b0, 2'd1);
    tick(13);
    check_out("btn_reseq_run", 3'd4, 1'b0, 1'b1, 2'd1);
    $display("txn btn_press: state=%0d cause=%0d", state, reset_cause);

`ifdef WATCHDOG_EN
    // Regular kicks keep RUN alive; timeout 20 cycles after the last kick.
    for (int k = 0; k < 5; k++) begin
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      tick(9);
      check_out("wdt_kicked", 3'd4, 1'b0, 1'b1, 2'd1);
    end
    tick(10);
    check_out("wdt_edge", 3'd4, 1'b0, 1'b1, 2'd1);
    tick(1);
    check_out("wdt_timeout", 3'd1, 1'b1, 1'b0, 2'd3);
    $display("txn watchdog: state=%0d cause=%0d", state, reset_cause);
`else
    // Without the watchdog, no kicks must not disturb RUN.
    tick(40);
    check_out("no_wdt", 3'd4, 1'b0, 1'b1, 2'd1);
    $display("txn no_watchdog: state=%0d cause=%0d", state, reset_cause);
`endif

    // rst during STABILIZE clears cause and returns to S_RESET.
    rst = 1'b1;
    tick(1);
    check_out("rst_again", 3'd0, 1'b1, 1'b0, 2'd0);
    rst = 1'b0;
    tick(4);
    check_out("stab_again", 3'd2, 1'b1, 1'b0, 2'd0);
    rst = 1'b1;
    tick(1);
    check_out("rst_in_stab", 3'd0, 1'b1, 1'b0, 2'd0);
    rst = 1'b0;
    tick(1);
    check_out("after_rst_stab", 3'd1, 1'b1, 1'b0, 2'd0);
    $display("txn rst_in_stab: state=%0d cause=%0d", state, reset_cause);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
